// File: rtl/r22sdf_stage_cfg_if.sv
// r22sdf_stage_cfg_if: sample stream, configuration and status bundle for the configurable R22SDF stage
// master drives i_cfg_load/i_cfg_log/i_half_sel/i_data/i_valid and observes o_data/o_valid/o_primed;
// slave is the stage itself.
interface r22sdf_stage_cfg_if #(
  parameter int DWIDTH = 32,
  parameter int CFG_W = 4
);
  logic i_cfg_load;
  logic [CFG_W-1:0] i_cfg_log;
  logic i_half_sel;
  logic [DWIDTH-1:0] i_data;
  logic i_valid;
  logic [DWIDTH-1:0] o_data;
  logic o_valid;
  logic o_primed;
  modport master (
    output i_cfg_load, i_cfg_log, i_half_sel, i_data, i_valid,
    input o_data, o_valid, o_primed
  );
  modport slave (
    input i_cfg_load, i_cfg_log, i_half_sel, i_data, i_valid,
    output o_data, o_valid, o_primed
  );
endinterface

// File: rtl/r22sdf_stage_cfg.sv
// r22sdf_stage_cfg: runtime-configurable radix-2^2 SDF FFT stage (BF2I delay 2^L, BF2II delay 2^(L-1))
// Ports: clk, reset (sync, active-high), bus (slave): i_cfg_load pulse latches i_cfg_log/i_half_sel and
// restarts; i_data/i_valid stream in; o_data/o_valid stream out 2 cycles later; o_primed after priming.
module r22sdf_stage_cfg #(
  parameter int DWIDTH = 32,
  parameter int MAX_LOG = 9,
  parameter int CFG_W = 4,
  parameter bit SCALE = 1
) (
  input logic clk,
  input logic reset,
  r22sdf_stage_cfg_if.slave bus
);
  localparam int HW = DWIDTH / 2;
  localparam int CW = MAX_LOG + 1;
  localparam int N1_MAX = 1 << MAX_LOG;
  localparam int N2_MAX = 1 << (MAX_LOG - 1);
  logic [CFG_W-1:0] cfg_log, cfg_sat;
  logic half;
  logic [CW-1:0] c, pc, s1_c, n1, n2, wrap, prime;
  logic s1_v, s1_ok, accept, hi1, hi2, rot;
  logic [DWIDTH-1:0] s1_data, s1_next, d1, w1, d2, w2, y, out2;
  logic [MAX_LOG-1:0] addr1;
  logic [MAX_LOG-2:0] addr2;
  logic [DWIDTH-1:0] mem1 [N1_MAX];
  logic [DWIDTH-1:0] mem2 [N2_MAX];
  function automatic logic [HW-1:0] bf(input logic [HW-1:0] a, input logic [HW-1:0] b, input logic sub);
    logic [HW:0] r;
    r = sub ? {a[HW-1], a} - {b[HW-1], b} : {a[HW-1], a} + {b[HW-1], b};
    return SCALE ? r[HW:1] : r[HW-1:0];
  endfunction
  function automatic logic [DWIDTH-1:0] cbf(input logic [DWIDTH-1:0] a, input logic [DWIDTH-1:0] b, input logic sub);
    return {bf(a[DWIDTH-1:HW], b[DWIDTH-1:HW], sub), bf(a[HW-1:0], b[HW-1:0], sub)};
  endfunction
  assign cfg_sat = bus.i_cfg_log == '0 ? CFG_W'(1) :
                   bus.i_cfg_log > CFG_W'(MAX_LOG) ? CFG_W'(MAX_LOG) : bus.i_cfg_log;
  assign n1 = CW'(1) << cfg_log;
  assign n2 = n1 >> 1;
  assign wrap = n1 | (n1 - CW'(1));
  assign prime = half ? n2 : n1 + n2;
  assign accept = bus.i_valid & ~bus.i_cfg_load;
  // Delay lines are circular buffers addressed by the sample count modulo their active length,
  // so each entry is read back exactly N accepted samples after it was written.
  assign addr1 = MAX_LOG'(c) & MAX_LOG'(n1 - CW'(1));
  assign addr2 = s1_c[MAX_LOG-2:0] & (MAX_LOG-1)'(n2 - CW'(1));
  assign hi1 = |(c & n1);
  assign hi2 = |(s1_c & n2);
  // BF2II stream position is the BF2I count minus N1, i.e. bit L flipped; quarter 3 is bit L clear, bit L-1 set.
  assign rot = ~half & ~|(s1_c & n1) & hi2;
  assign d1 = mem1[addr1];
  assign d2 = mem2[addr2];
  always_comb begin
    s1_next = half ? bus.i_data : hi1 ? cbf(d1, bus.i_data, 1'b0) : d1;
    w1 = hi1 ? cbf(d1, bus.i_data, 1'b1) : bus.i_data;
    y = rot ? {s1_data[HW-1:0], -s1_data[DWIDTH-1:HW]} : s1_data;
    out2 = hi2 ? cbf(d2, y, 1'b0) : d2;
    w2 = hi2 ? cbf(d2, y, 1'b1) : y;
  end
  always_ff @(posedge clk) begin
    if (reset || bus.i_cfg_load) begin
      cfg_log <= reset ? CFG_W'(MAX_LOG) : cfg_sat;
      half <= reset ? 1'b0 : bus.i_half_sel;
      c <= '0;
      pc <= '0;
      s1_c <= '0;
      s1_v <= 1'b0;
      s1_ok <= 1'b0;
      s1_data <= '0;
      bus.o_data <= '0;
      bus.o_valid <= 1'b0;
      bus.o_primed <= 1'b0;
    end else begin
      s1_v <= accept;
      if (accept) begin
        c <= (c + CW'(1)) & wrap;
        pc <= pc == prime ? pc : pc + CW'(1);
        s1_ok <= pc == prime;
        s1_c <= c;
        s1_data <= s1_next;
      end
      if (s1_v) bus.o_data <= out2;
      bus.o_valid <= s1_v & s1_ok;
      bus.o_primed <= bus.o_primed | (s1_v & s1_ok);
    end
  end
  // Delay contents need no reset: output stays suppressed until every read entry has been rewritten.
  always_ff @(posedge clk) begin
    if (accept && !half) mem1[addr1] <= w1;
    if (s1_v) mem2[addr2] <= w2;
  end
endmodule

// File: tb/tb_r22sdf_stage_cfg.sv
// tb_r22sdf_stage_cfg: directed self-checking bench for r22sdf_stage_cfg (SCALE=0 and SCALE=1 instances)
module tb_r22sdf_stage_cfg;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  r22sdf_stage_cfg_if #(.DWIDTH(32), .CFG_W(4)) b0 ();
  r22sdf_stage_cfg_if #(.DWIDTH(32), .CFG_W(4)) b1 ();
  r22sdf_stage_cfg #(.DWIDTH(32), .MAX_LOG(9), .CFG_W(4), .SCALE(0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  r22sdf_stage_cfg #(.DWIDTH(32), .MAX_LOG(9), .CFG_W(4), .SCALE(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] q0[$], q1[$], ex[$];
  int t0[$], tin[$];
  int s1a [12] = '{4, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
  int s1b [12] = '{16, 0, 0, 0, 4, 4, 4, 4, 0, 0, 0, 0};
  int r1 [9] = '{4, 4, 4, 4, 4, 0, 0, 0, 0};
  int s2in [8] = '{0, 1, 0, 0, 0, 0, 0, 0};
  int r2 [5] = '{1, -1, 0, 0, 0};
  int i2 [5] = '{0, 0, -1, 1, 0};
  int s5in [8] = '{3, 0, 1, 0, 0, 0, 0, 0};
  int r5 [6] = '{4, 0, 2, 0, 0, 0};
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (b0.o_valid) begin
      q0.push_back(b0.o_data);
      t0.push_back(cyc);
    end
    if (b1.o_valid) q1.push_back(b1.o_data);
  end
  function automatic logic [31:0] cx(input int re, input int im);
    return {re[15:0], im[15:0]};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    q0.delete();
    q1.delete();
    t0.delete();
    tin.delete();
  endtask
  task automatic send(input int a0, input int a1);
    b0.i_valid = 1'b1;
    b1.i_valid = 1'b1;
    b0.i_data = cx(a0, 0);
    b1.i_data = cx(a1, 0);
    tin.push_back(cyc);
    step();
    b0.i_valid = 1'b0;
    b1.i_valid = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) step();
  endtask
  task automatic load(input int l, input bit h);
    b0.i_cfg_load = 1'b1;
    b1.i_cfg_load = 1'b1;
    b0.i_cfg_log = l[3:0];
    b1.i_cfg_log = l[3:0];
    b0.i_half_sel = h;
    b1.i_half_sel = h;
    step();
    b0.i_cfg_load = 1'b0;
    b1.i_cfg_load = 1'b0;
    clr();
  endtask
  task automatic expect_seq(input string tag, input logic [31:0] got[$]);
    chk({tag, " count"}, 32'(got.size()), 32'(ex.size()));
    foreach (ex[i]) chk($sformatf("%s data[%0d]", tag, i), i < got.size() ? got[i] : 32'bx, ex[i]);
  endtask
  task automatic expect_lat(input string tag, input int p);
    foreach (t0[i]) chk($sformatf("%s latency[%0d]", tag, i), 32'(t0[i]),
                        (i + p < tin.size()) ? 32'(tin[i + p] + 2) : 32'hffff_ffff);
  endtask
  initial begin
    reset = 1'b1;
    b0.i_cfg_load = 1'b0; b1.i_cfg_load = 1'b0;
    b0.i_cfg_log = '0;    b1.i_cfg_log = '0;
    b0.i_half_sel = 1'b0; b1.i_half_sel = 1'b0;
    b0.i_data = '0;       b1.i_data = '0;
    b0.i_valid = 1'b0;    b1.i_valid = 1'b0;
    idle(3);
    chk("reset o_data", b0.o_data, 32'h0);
    chk("reset o_valid", 32'(b0.o_valid), 32'h0);
    chk("reset o_primed", 32'(b0.o_primed), 32'h0);
    reset = 1'b0;
    idle(1);
    // impulse then all-ones then zeros, L=1 full; SCALE=1 copy gets amplitudes 16 and 4
    load(1, 1'b0);
    foreach (s1a[i]) send(s1a[i], s1b[i]);
    idle(4);
    ex.delete();
    foreach (r1[i]) ex.push_back(cx(r1[i], 0));
    expect_seq("s1 scale0", q0);
    expect_seq("s1 scale1", q1);
    expect_lat("s1", 3);
    // L=0 saturates to 1; frame (0,1,0,0)
    load(0, 1'b0);
    foreach (s2in[i]) send(s2in[i], s2in[i]);
    idle(4);
    ex.delete();
    foreach (r2[i]) ex.push_back(cx(r2[i], i2[i]));
    expect_seq("s2 twiddle", q0);
    expect_lat("s2", 3);
    // same stream with random idle gaps
    load(1, 1'b0);
    foreach (s1a[i]) begin
      idle($urandom_range(0, 5));
      send(s1a[i], s1b[i]);
    end
    idle(4);
    ex.delete();
    foreach (r1[i]) ex.push_back(cx(r1[i], 0));
    expect_seq("s3 gaps", q0);
    expect_lat("s3", 3);
    // half mode, L=2
    load(2, 1'b1);
    chk("s4 primed after load", 32'(b0.o_primed), 32'h0);
    send(s5in[0], s5in[0]);
    send(s5in[1], s5in[1]);
    chk("s4 primed before output", 32'(b0.o_primed), 32'h0);
    send(s5in[2], s5in[2]);
    send(s5in[3], s5in[3]);
    chk("s4 primed", 32'(b0.o_primed), 32'h1);
    for (int i = 4; i < 8; i++) send(s5in[i], s5in[i]);
    idle(4);
    ex.delete();
    foreach (r5[i]) ex.push_back(cx(r5[i], 0));
    expect_seq("s4 half", q0);
    expect_lat("s4", 2);
    // mid-stream reload to L=3 with a sample in the load cycle
    load(1, 1'b0);
    for (int i = 0; i < 6; i++) send(s1a[i], s1b[i]);
    b0.i_valid = 1'b1; b1.i_valid = 1'b1;
    b0.i_data = cx(7, 0); b1.i_data = cx(7, 0);
    load(3, 1'b0);
    b0.i_valid = 1'b0; b1.i_valid = 1'b0;
    chk("s5 o_valid after load", 32'(b0.o_valid), 32'h0);
    chk("s5 o_data after load", b0.o_data, 32'h0);
    chk("s5 o_primed after load", 32'(b0.o_primed), 32'h0);
    for (int i = 0; i < 14; i++) send(0, 0);
    idle(4);
    ex.delete();
    ex.push_back(32'h0);
    ex.push_back(32'h0);
    expect_seq("s5 reload", q0);
    expect_lat("s5", 12);
    // reset mid-frame together with a load: reset wins, giving L=9 full (P=768)
    load(1, 1'b0);
    for (int i = 0; i < 6; i++) send(s1a[i], s1b[i]);
    reset = 1'b1;
    b0.i_valid = 1'b1;
    load(2, 1'b1);
    reset = 1'b0;
    b0.i_valid = 1'b0;
    chk("s6 o_valid after reset", 32'(b0.o_valid), 32'h0);
    chk("s6 o_primed after reset", 32'(b0.o_primed), 32'h0);
    chk("s6 o_data after reset", b0.o_data, 32'h0);
    for (int i = 0; i < 20; i++) send(0, 0);
    idle(3);
    chk("s6 no early output", 32'(q0.size()), 32'h0);
    for (int i = 20; i < 770; i++) send(0, 0);
    idle(4);
    ex.delete();
    ex.push_back(32'h0);
    ex.push_back(32'h0);
    expect_seq("s6 default cfg", q0);
    expect_lat("s6", 768);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/r22sdf_stage_cfg.md
Name: r22sdf_stage_cfg

Overview:
- Runtime-configurable radix-2^2 single-path delay-feedback (R22SDF) FFT stage: a BF2I butterfly (feedback delay N1 = 2^L) followed by a BF2II butterfly (feedback delay N2 = 2^(L-1)) with trivial -j rotation.
- Generalises the fixed last stage: the delay length, half (odd-power, radix-2-only) mode and per-butterfly scaling are selectable, so one instance serves every FFT size up to 2^(MAX_LOG+1) points.
- Streams one complex sample per accepted i_valid. Output is in bit-reversed order, as the rest of the pipeline expects.

Parameters:
- DWIDTH, 32: packed complex width; {re, im}, each DWIDTH/2 bits, signed two's complement (re in the upper half).
- MAX_LOG, 9: maximum L; delay storage sized 2^MAX_LOG (BF2I) + 2^(MAX_LOG-1) (BF2II).
- CFG_W, 4: width of i_cfg_log; must hold MAX_LOG.
- SCALE, 1: 1 = each butterfly result arithmetic-shifted right by 1 (truncate); 0 = full-rate, wraps modulo 2^(DWIDTH/2).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_cfg_load  in  1  one-cycle pulse; captures i_cfg_log and i_half_sel and restarts the stage
- i_cfg_log  in  CFG_W  L, legal range 1..MAX_LOG
- i_half_sel  in  1  1 = BF2I bypassed; BF2II runs as a plain radix-2 butterfly with delay N2 and no -j rotation
- i_data  in  DWIDTH  input sample
- i_valid  in  1  sample qualifier (no backpressure)
- o_data  out  DWIDTH  output sample
- o_valid  out  1  output qualifier
- o_primed  out  1  high once priming is complete

Behaviour:
- Reset:
  - o_data=0, o_valid=0, o_primed=0; all counters cleared.
  - Config registers = {L=MAX_LOG, half=0}.
  - Delay contents are don't-care, because output is suppressed until priming completes.
- i_cfg_load:
  - Same clearing as reset, except the config registers take the new values.
  - Reset wins if both are asserted in the same cycle.
  - An i_valid in the load cycle is discarded.
  - Illegal L (0 or >MAX_LOG) saturates to the nearest legal value.
- Delay lines:
  - Sample-driven: shift or write only on accepted samples; hold when i_valid=0.
  - Only the first 2^L / 2^(L-1) entries are active.
- Input counter:
  - c, (MAX_LOG+1) bits, increments per accepted sample; wraps at 2·N1.
- BF2I (sample x, delay output d):
  - First half (c[L]=0): write x, emit d.
  - Second half: emit d+x, write d−x.
- BF2II:
  - Operates on BF2I outputs, one cycle after input; q = quarter index of the output stream, offset by N1.
  - If q=3, apply −j: (a+jb) becomes (b − ja), with exact negation that wraps at the most-negative value.
  - Then the same half-block butterfly with delay N2.
- Half mode:
  - BF2I becomes a one-cycle register.
  - BF2II uses delay N2 and no rotation.
- Scaling: applied independently on every butterfly sum/difference when SCALE=1; pass-through samples are never scaled.
- Latency: o_valid follows an accepted i_valid by exactly 2 cycles (BF2I register, BF2II output register), once primed.
- Priming:
  - P = N1+N2 (full) or N2 (half) accepted samples after reset/load.
  - o_valid=0 for those samples; o_primed rises with the first valid output.
- i_valid gaps of any length do not alter the data sequence, only its timing.
- The tail of the last frame emerges only as the next frame streams in; no flush port.

Test Plan:
- L=1, full, SCALE=0. After load, send (4,0,0,0), then (1,1,1,1), then (0,0,0,0) as real frames, back-to-back.
  - Required: first o_valid 2 cycles after the 4th input.
  - Outputs X0,X2,X1,X3 = (4,4,4,4), then (4,0,0,0).
- L=1, full, SCALE=0. Input frame (0,1,0,0) real.
  - Required: X0,X2,X1,X3 = 1, −1, −j, +j; i.e. packed (1,0), (−1,0), (0,−1), (0,1).
- The scenario-1 stream with SCALE=1 and impulse amplitude 16.
  - Required: each bin = 4 (16 >> 2).
  - All-ones frame of amplitude 4 gives X0=4 and other bins 0.
- Scenario-1 stream with random i_valid gaps (0–5 cycles).
  - Required: identical o_data sequence.
  - Every output 2 cycles after its triggering input.
- i_half_sel=1, L=2 (N2=2). Input (3,0,1,0) then zeros.
  - Required: o_primed after 2 samples.
  - Outputs 4,0,2,0: BF2II radix-2 with no −j.
- Mid-stream i_cfg_load to L=3, and reset asserted mid-frame.
  - Required: o_valid drops the next cycle and stays low for 12 / P new samples.
  - No stale data appears; reset in the same cycle as load wins.
